xor_frame_acc: RTL and testbench

XOR_FRAME_ACC -- requirements
Module: xor_frame_acc

---
 rtl/xor_frame_acc_pkg.sv | 18 +
 rtl/xor_frame_acc_xor_reduce.sv | 13 +
 rtl/xor_frame_acc.sv | 143 ++++++++++++++
 tb/tb_xor_frame_acc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/xor_frame_acc_pkg.sv
// Shared types and defaults for the XOR frame accumulator.
// Optional frame-check feature is enabled by macro XOR_FRAME_ACC_CHECK_EN.
package xor_frame_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH     = 32'd8;
    localparam int unsigned DEFAULT_MAX_WORDS = 32'd16;

    // Words up to 64 bits are zero-extended, which leaves the parity unchanged.
    function automatic logic parity64(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/xor_frame_acc_xor_reduce.sv
// Single-bit XOR reduction of a WIDTH-bit word (1..64 bits).
module xor_reduce
    import xor_frame_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] word,
    output logic             result
);

    assign result = parity64(64'(word));

endmodule

// File: rtl/xor_frame_acc.sv
// Frame XOR accumulator: folds beats until in_last or MAX_WORDS, then holds the result.
// Define XOR_FRAME_ACC_CHECK_EN to add the exp_xor input and out_match output.
module xor_frame_acc
    import xor_frame_acc_pkg::*;
#(
    parameter  int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter  int unsigned MAX_WORDS = DEFAULT_MAX_WORDS,
    localparam int unsigned CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
`ifdef XOR_FRAME_ACC_CHECK_EN
    input  logic [WIDTH-1:0] exp_xor,
    output logic             out_match,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_xor,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_trunc
);

    state_e           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_xor_r;
    logic             out_parity_r;
    logic [CW-1:0]    out_count_r;
    logic             out_trunc_r;

    logic [WIDTH-1:0] next_xor_s;
    logic [CW-1:0]    next_cnt_s;
    logic             next_parity_s;
    logic             accept_s;
    logic             at_max_s;
    logic             close_s;
    logic             trunc_s;

    // Next accumulator value and frame-closing decision for the offered beat.
    always_comb begin
        next_xor_s = acc_r ^ in_data;
        next_cnt_s = cnt_r + CW'(1);
        accept_s   = in_valid & in_ready_r;
        at_max_s   = (next_cnt_s == CW'(MAX_WORDS));
        if (accept_s) begin
            close_s = in_last | at_max_s;
            trunc_s = ~in_last & at_max_s;
        end else begin
            close_s = 1'b0;
            trunc_s = 1'b0;
        end
    end

    // Parity is computed on the value being loaded so out_parity is a register.
    xor_reduce #(.WIDTH(WIDTH)) u_parity (
        .word   (next_xor_s),
        .result (next_parity_s)
    );

    // ACC/HOLD state machine with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ACC;
            acc_r        <= {WIDTH{1'b0}};
            cnt_r        <= {CW{1'b0}};
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_xor_r    <= {WIDTH{1'b0}};
            out_parity_r <= 1'b0;
            out_count_r  <= {CW{1'b0}};
            out_trunc_r  <= 1'b0;
        end else begin
            case (state_r)
                ACC: begin
                    if (close_s) begin
                        state_r      <= HOLD;
                        in_ready_r   <= 1'b0;
                        out_valid_r  <= 1'b1;
                        out_xor_r    <= next_xor_s;
                        out_parity_r <= next_parity_s;
                        out_count_r  <= next_cnt_s;
                        out_trunc_r  <= trunc_s;
                    end else if (accept_s) begin
                        acc_r <= next_xor_s;
                        cnt_r <= next_cnt_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= ACC;
                        acc_r       <= {WIDTH{1'b0}};
                        cnt_r       <= {CW{1'b0}};
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r     <= ACC;
                    acc_r       <= {WIDTH{1'b0}};
                    cnt_r       <= {CW{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef XOR_FRAME_ACC_CHECK_EN
    logic out_match_r;

    // Expected value arrives with the closing beat; the verdict is held with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_match_r <= 1'b0;
        end else if (close_s) begin
            out_match_r <= (next_xor_s == exp_xor);
        end else begin
            out_match_r <= out_match_r;
        end
    end

    assign out_match = out_match_r;
`endif

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_xor    = out_xor_r;
    assign out_parity = out_parity_r;
    assign out_count  = out_count_r;
    assign out_trunc  = out_trunc_r;

endmodule

// File: tb/tb_xor_frame_acc.sv
// Directed self-checking bench for xor_frame_acc (WIDTH=8, MAX_WORDS=16).
module tb_xor_frame_acc;
    import xor_frame_acc_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned MW = 16;
    localparam int unsigned CW = $clog2(MW + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_xor;
    logic          out_parity;
    logic [CW-1:0] out_count;
    logic          out_trunc;
`ifdef XOR_FRAME_ACC_CHECK_EN
    logic [W-1:0]  exp_xor;
    logic          out_match;
`endif

    int checks   = 0;
    int failures = 0;
    int waited;

    xor_frame_acc #(.WIDTH(W), .MAX_WORDS(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
`ifdef XOR_FRAME_ACC_CHECK_EN
        .exp_xor    (exp_xor),
        .out_match  (out_match),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_xor    (out_xor),
        .out_parity (out_parity),
        .out_count  (out_count),
        .out_trunc  (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat, waiting (bounded) for in_ready; returns stalled cycles.
    task automatic send(input logic [W-1:0] d, input logic l, output int stall);
        stall    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && stall < 20) begin
            @(posedge clk); #1;
            stall++;
        end
        if (stall >= 20) chk("ready_timeout", 64'(stall), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] x, input logic p,
                              input logic [CW-1:0] c, input logic t);
        chk({tag, "_valid"},  64'(out_valid),  64'd1);
        chk({tag, "_xor"},    64'(out_xor),    64'(x));
        chk({tag, "_parity"}, 64'(out_parity), 64'(p));
        chk({tag, "_count"},  64'(out_count),  64'(c));
        chk({tag, "_trunc"},  64'(out_trunc),  64'(t));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
`ifdef XOR_FRAME_ACC_CHECK_EN
        exp_xor = 8'h96;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_valid",  64'(out_valid),  64'd0);
        chk("rst_ready",  64'(in_ready),   64'd1);
        chk("rst_xor",    64'(out_xor),    64'd0);
        chk("rst_parity", 64'(out_parity), 64'd0);
        chk("rst_count",  64'(out_count),  64'd0);
        chk("rst_trunc",  64'(out_trunc),  64'd0);
`ifdef XOR_FRAME_ACC_CHECK_EN
        chk("rst_match",  64'(out_match),  64'd0);
`endif

        // Three-beat frame: A5 ^ 0F ^ 3C = 96, even parity.
        send(8'hA5, 1'b0, waited);
        send(8'h0F, 1'b0, waited);
        chk("f3_mid_valid", 64'(out_valid), 64'd0);
        send(8'h3C, 1'b1, waited);
        chk_result("f3", 8'h96, 1'b0, 5'd3, 1'b0);
        chk("f3_ready", 64'(in_ready), 64'd0);
`ifdef XOR_FRAME_ACC_CHECK_EN
        chk("f3_match", 64'(out_match), 64'd1);
`endif
        pop();
        chk("pop_valid", 64'(out_valid), 64'd0);
        chk("pop_ready", 64'(in_ready),  64'd1);

`ifdef XOR_FRAME_ACC_CHECK_EN
        exp_xor = 8'h97;
        send(8'hA5, 1'b0, waited);
        send(8'h0F, 1'b0, waited);
        send(8'h3C, 1'b1, waited);
        chk("f3b_match", 64'(out_match), 64'd0);
        pop();
`endif

        // Single-beat frame, then five stalled cycles with a beat offered.
        send(8'h01, 1'b1, waited);
        chk_result("one", 8'h01, 1'b1, 5'd1, 1'b0);
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_xor",   64'(out_xor),  64'h01);
            chk("hold_count", 64'(out_count), 64'd1);
            chk("hold_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        pop();

        // Sixteen beats without last are force-closed.
        for (int i = 0; i < 15; i++) send(8'hFF, 1'b0, waited);
        chk("max15_valid", 64'(out_valid), 64'd0);
        send(8'hFF, 1'b0, waited);
        chk_result("trunc", 8'h00, 1'b0, 5'd16, 1'b1);
        pop();

        // Closing beat both last and at the limit is not a truncation.
        for (int i = 0; i < 15; i++) send(8'hFF, 1'b0, waited);
        send(8'hFF, 1'b1, waited);
        chk_result("maxlast", 8'h00, 1'b0, 5'd16, 1'b0);
        pop();

        // Reset mid-frame discards the partial accumulation.
        send(8'h11, 1'b0, waited);
        send(8'h22, 1'b0, waited);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_count", 64'(out_count), 64'd0);
        send(8'h55, 1'b1, waited);
        chk_result("after_rst", 8'h55, 1'b0, 5'd1, 1'b0);
        pop();

        // Back-to-back frames with the consumer always ready.
        out_ready = 1'b1;
        send(8'h12, 1'b0, waited);
        send(8'h34, 1'b1, waited);
        chk_result("b2b1", 8'h26, 1'b1, 5'd2, 1'b0);
        send(8'h56, 1'b1, waited);
        chk("b2b2_idle", 64'(waited), 64'd1);
        chk_result("b2b2", 8'h56, 1'b0, 5'd1, 1'b0);
        send(8'hF0, 1'b0, waited);
        chk("b2b3_idle", 64'(waited), 64'd1);
        send(8'h0F, 1'b0, waited);
        send(8'hAA, 1'b1, waited);
        chk_result("b2b3", 8'h55, 1'b0, 5'd3, 1'b0);
        @(posedge clk); #1;
        chk("b2b_drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
